instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encoder counterpart to the core's instruction decoder/control unit.
- Accepts decoded micro-op commands (kind, aluop code, register indices, immediate) over a valid/ready handshake.
- Assembles the RV32IM instruction word for each command and writes it sequentially into instruction memory.
- Used by the boot/program-load path and by self-check benches, which produce instruction streams from the same aluop codes the decoder emits.

Parameters:
- ADDR_W, 12: instruction-memory word-address width. Capacity DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous restart: count=0, err=0, FSM to IDLE.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  encoder can accept a command.
- cmd_kind  input  2  command kind: 0=R, 1=I (OP-IMM), 2=U (lui), 3=CSRRW.
- cmd_aluop  input  4  ALU op code, decoder encoding.
- cmd_rd  input  5  destination register.
- cmd_rs1  input  5  source register 1.
- cmd_rs2  input  5  source register 2.
- cmd_imm  input  20  immediate. I-type uses [11:0]; U-type uses [19:0]; CSRRW uses [11:0] as CSR number.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words written.
- full  output  1  count==DEPTH.
- err  output  1  sticky illegal-command flag.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; cmd_ready=0 during reset, 1 on the first cycle after release; mem_we=0; mem_addr=0; mem_wdata=0; count=0; full=0; err=0.
- FSM states: IDLE, ENC, WRITE.
  - IDLE: cmd_ready = !full && !clear. A handshake (cmd_valid && cmd_ready) registers all command fields and moves to ENC.
  - ENC: combinational encode of the registered fields into a registered word, plus a legality check, then go to WRITE. If illegal: set err, no write, return to IDLE.
  - WRITE: mem_we=1 for exactly one cycle; mem_addr=count[ADDR_W-1:0]; count increments; return to IDLE.
- Latency: handshake at edge T gives mem_we high during cycle T+2. Sustained throughput is one word per 3 cycles.
- cmd_ready is low in ENC and WRITE. Fields on the cmd_* inputs outside the handshake are ignored.
- Encoding:
  - R-type: opcode 0110011.
    - funct7=0000000: aluop 0011 add f3=000; 0000 and 111; 0001 or 110; 0010 xor 100; 1000 sll 001; 1001 srl 101; 1100 slt 010; 1101 sltu 011.
    - funct7=0100000: 0100 sub 000; 1010 sra 101.
    - funct7=0000001: 0101 mul 000; 0110 mulh 001; 0111 mulhu 011.
  - I-type: opcode 0010011. Valid aluops: add, and, or, xor, sll, srl, sra.
    - imm[11:0] goes to word [31:20].
    - For shifts, [31:25]=0000000 (sll, srl) or 0100000 (sra), and [24:20]=imm[4:0].
  - U-type: opcode 0110111, [31:12]=imm[19:0], [11:7]=rd.
  - CSRRW: opcode 1110011, f3=001, [31:20]=imm[11:0], rs1, rd.
  - rs2 is used only by R-type; the rs2 field is imm-derived elsewhere.
- Illegal: any aluop not listed for the command kind (cmd_aluop ignored for kinds 2 and 3).
- Full: when count==DEPTH, full=1 and cmd_ready=0. Commands stall; nothing wraps or overwrites.
- clear: when high, takes priority over everything. Any pending ENC/WRITE is aborted with no mem_we; cmd_ready=0 that cycle. Next cycle: IDLE, count=0, err=0, full=0.
- Reset mid-operation: mem_we drops immediately; the partial command is discarded.

Optional Feature:
- Macro: INSTR_ENC_NOP_ON_ERR_EN.
- Defined: an illegal command still sets err but proceeds to WRITE with mem_wdata=32'h00000013 (addi x0,x0,0). Address and count advance, so stream positions stay aligned.
- Undefined: an illegal command is dropped and no write occurs.

Test Plan:
- R add (aluop 0011, rd=3, rs1=1, rs2=2) handshake at T -> mem_we at T+2, mem_addr=0, mem_wdata=0x002081B3, count=1.
- R sub x5,x6,x7 -> 0x407302B3. I addi x1,x0,imm=0xFFF -> 0xFFF00093. I sra x2,x2,imm=3 -> 0x40315113. Addresses 1, 2, 3.
- U lui x10, imm=0x12345 -> 0x12345537. CSRRW rd=0, rs1=4, imm=0xF00 -> 0xF0021073.
- R with aluop 1111 -> err=1 and no mem_we, count unchanged. With INSTR_ENC_NOP_ON_ERR_EN: mem_wdata=0x00000013, count+1.
- ADDR_W=2, five back-to-back commands -> four writes at addresses 0..3, full=1, cmd_ready=0, fifth command held. clear -> count=0, cmd_ready=1 the following cycle.
- rst_n asserted during WRITE -> mem_we=0 immediately, count=0. clear asserted in ENC -> no write occurs.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: assembles RV32IM words from decoded micro-op commands and writes them to
// consecutive instruction-memory words. Build option macro: INSTR_ENC_NOP_ON_ERR_EN.
//
// Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready are both
// high; cmd_ready is raised only in IDLE with room left, and cmd_* are ignored otherwise.
module instr_encoder #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [3:0]        cmd_aluop,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [19:0]       cmd_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [31:0]     NOP_WORD = 32'h0000_0013;

  localparam logic [1:0] K_R   = 2'd0;
  localparam logic [1:0] K_I   = 2'd1;
  localparam logic [1:0] K_U   = 2'd2;
  localparam logic [1:0] K_CSR = 2'd3;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU op codes as emitted by the core's decoder
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_MULH  = 4'b0110;
  localparam logic [3:0] ALU_MULHU = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [1:0]      r_kind;
  logic [3:0]      r_aluop;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [19:0]     r_imm;
  logic [31:0]     r_word;
  logic [ADDR_W:0] r_count;
  logic            r_err;

  logic            w_accept;
  logic            w_full;
  logic [6:0]      w_funct7;
  logic [2:0]      w_funct3;
  logic            w_r_ok;
  logic            w_i_ok;
  logic            w_is_shift;
  logic [11:0]     w_i_imm;
  logic [31:0]     w_word;
  logic            w_legal;

  assign w_full   = (r_count == DEPTH);
  assign w_accept = cmd_valid && cmd_ready;

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) w_next_state = S_ENC;
        end
        S_ENC: begin
`ifdef INSTR_ENC_NOP_ON_ERR_EN
          w_next_state = S_WRITE;
`else
          w_next_state = w_legal ? S_WRITE : S_IDLE;
`endif
        end
        S_WRITE: w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM: outputs
  // rst_n gates cmd_ready so it stays low while reset is held, yet rises right after release.
  always_comb begin
    cmd_ready = rst_n && (r_state == S_IDLE) && !w_full && !clear;
    mem_we    = (r_state == S_WRITE) && !clear;
  end

  // ---------------------------------------------------------------- field decode
  always_comb begin
    w_funct7 = F7_BASE;
    w_funct3 = 3'b000;
    w_r_ok   = 1'b1;
    w_i_ok   = 1'b1;
    case (r_aluop)
      ALU_ADD:   w_funct3 = 3'b000;
      ALU_AND:   w_funct3 = 3'b111;
      ALU_OR:    w_funct3 = 3'b110;
      ALU_XOR:   w_funct3 = 3'b100;
      ALU_SLL:   w_funct3 = 3'b001;
      ALU_SRL:   w_funct3 = 3'b101;
      ALU_SLT: begin
        w_funct3 = 3'b010;
        w_i_ok   = 1'b0;
      end
      ALU_SLTU: begin
        w_funct3 = 3'b011;
        w_i_ok   = 1'b0;
      end
      ALU_SUB: begin
        w_funct7 = F7_ALT;
        w_funct3 = 3'b000;
        w_i_ok   = 1'b0;
      end
      ALU_SRA: begin
        w_funct7 = F7_ALT;
        w_funct3 = 3'b101;
      end
      ALU_MUL: begin
        w_funct7 = F7_MULDIV;
        w_funct3 = 3'b000;
        w_i_ok   = 1'b0;
      end
      ALU_MULH: begin
        w_funct7 = F7_MULDIV;
        w_funct3 = 3'b001;
        w_i_ok   = 1'b0;
      end
      ALU_MULHU: begin
        w_funct7 = F7_MULDIV;
        w_funct3 = 3'b011;
        w_i_ok   = 1'b0;
      end
      default: begin
        w_r_ok = 1'b0;
        w_i_ok = 1'b0;
      end
    endcase
  end

  // Immediate shifts carry funct7 in the upper immediate bits and only a 5-bit shamt.
  assign w_is_shift = (r_aluop == ALU_SLL) || (r_aluop == ALU_SRL) || (r_aluop == ALU_SRA);
  assign w_i_imm    = w_is_shift ? {w_funct7, r_imm[4:0]} : r_imm[11:0];

  // ---------------------------------------------------------------- word assembly
  always_comb begin
    w_word  = 32'h0;
    w_legal = 1'b1;
    case (r_kind)
      K_R: begin
        w_word  = {w_funct7, r_rs2, r_rs1, w_funct3, r_rd, OP_R};
        w_legal = w_r_ok;
      end
      K_I: begin
        w_word  = {w_i_imm, r_rs1, w_funct3, r_rd, OP_I};
        w_legal = w_i_ok;
      end
      K_U: begin
        w_word  = {r_imm, r_rd, OP_LUI};
      end
      K_CSR: begin
        w_word  = {r_imm[11:0], r_rs1, 3'b001, r_rd, OP_SYS};
      end
      default: begin
        w_word  = 32'h0;
        w_legal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- command capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind  <= 2'd0;
      r_aluop <= 4'd0;
      r_rd    <= 5'd0;
      r_rs1   <= 5'd0;
      r_rs2   <= 5'd0;
      r_imm   <= 20'd0;
    end else if (w_accept) begin
      r_kind  <= cmd_kind;
      r_aluop <= cmd_aluop;
      r_rd    <= cmd_rd;
      r_rs1   <= cmd_rs1;
      r_rs2   <= cmd_rs2;
      r_imm   <= cmd_imm;
    end
  end

  // ---------------------------------------------------------------- word, count, error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= 32'h0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_ENC) begin
        if (w_legal) begin
          r_word <= w_word;
        end else begin
          r_err  <= 1'b1;
`ifdef INSTR_ENC_NOP_ON_ERR_EN
          r_word <= NOP_WORD;
`endif
        end
      end
      if (r_state == S_WRITE) begin
        r_count <= r_count + CNT_ONE;
      end
    end
  end

`ifndef INSTR_ENC_NOP_ON_ERR_EN
  logic w_nop_unused;
  assign w_nop_unused = ^NOP_WORD;
`endif

  assign mem_addr  = r_count[ADDR_W-1:0];
  assign mem_wdata = r_word;
  assign count     = r_count;
  assign full      = w_full;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (small memory, ADDR_W=2): fixed vectors, hand-built corner sequences
// and random commands scored against an opcode-table reference model.
module tb_instr_encoder;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int W      = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              clear = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_kind = '0;
  logic [3:0]        cmd_aluop = '0;
  logic [4:0]        cmd_rd = '0;
  logic [4:0]        cmd_rs1 = '0;
  logic [4:0]        cmd_rs2 = '0;
  logic [19:0]       cmd_imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  logic [1:0]        dbg_state;

  instr_encoder #(.ADDR_W(ADDR_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_kind  (cmd_kind),
    .cmd_aluop (cmd_aluop),
    .cmd_rd    (cmd_rd),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_imm   (cmd_imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .full      (full),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, got no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- scoreboard state
  int              n_checks = 0;
  int              n_errors = 0;
  logic [W-1:0]    exp_q[$];
  int              mdl_count = 0;
  bit              mdl_err = 1'b0;

  // Reference opcode map, indexed by aluop
  bit r_legal [16];
  bit i_legal [16];
  int funct3  [16];
  int funct7  [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int op, input int f7, input int f3, input bit in_i);
    r_legal[op] = 1'b1;
    i_legal[op] = in_i;
    funct7[op]  = f7;
    funct3[op]  = f3;
  endtask

  task automatic init_tables();
    set_op(3,  0,  0, 1);  // add
    set_op(0,  0,  7, 1);  // and
    set_op(1,  0,  6, 1);  // or
    set_op(2,  0,  4, 1);  // xor
    set_op(8,  0,  1, 1);  // sll
    set_op(9,  0,  5, 1);  // srl
    set_op(12, 0,  2, 0);  // slt
    set_op(13, 0,  3, 0);  // sltu
    set_op(4,  32, 0, 0);  // sub
    set_op(10, 32, 5, 1);  // sra
    set_op(5,  1,  0, 0);  // mul
    set_op(6,  1,  1, 0);  // mulh
    set_op(7,  1,  3, 0);  // mulhu
  endtask

  function automatic bit ref_encode(input logic [1:0] kind, input logic [3:0] op,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [19:0] imm,
                                    output logic [31:0] word);
    longint w;
    bit     ok;
    int     immf;
    w  = 0;
    ok = 1'b1;
    case (kind)
      2'd0: begin
        ok = r_legal[op];
        w  = (longint'(funct7[op]) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15) |
             (longint'(funct3[op]) << 12) | (longint'(rd) << 7) | 64'h33;
      end
      2'd1: begin
        ok = i_legal[op];
        if (funct3[op] == 1 || funct3[op] == 5) immf = funct7[op] * 32 + int'(imm[4:0]);
        else                                    immf = int'(imm[11:0]);
        w  = (longint'(immf) << 20) | (longint'(rs1) << 15) | (longint'(funct3[op]) << 12) |
             (longint'(rd) << 7) | 64'h13;
      end
      2'd2: w = (longint'(imm) << 12) | (longint'(rd) << 7) | 64'h37;
      default: w = (longint'(imm[11:0]) << 20) | (longint'(rs1) << 15) | (64'd1 << 12) |
                   (longint'(rd) << 7) | 64'h73;
    endcase
    word = ok ? w[31:0] : 32'h13;
    return ok;
  endfunction

  // ---------------------------------------------------------------- monitor
  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {mem_addr, mem_wdata}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(mon_e[W-1:32]));
        check("write_data", 64'(mem_wdata), 64'(mon_e[31:0]));
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic expect_write(input logic [31:0] word);
    exp_q.push_back({ADDR_W'(mdl_count), word});
    mdl_count++;
  endtask

  task automatic expect_illegal();
    mdl_err = 1'b1;
`ifdef INSTR_ENC_NOP_ON_ERR_EN
    expect_write(32'h00000013);
`endif
  endtask

  // Returns 1ns after the accepting edge.
  task automatic handshake(input logic [1:0] kind, input logic [3:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [19:0] imm,
                           output bit ok);
    int waited;
    @(negedge clk);
    cmd_kind = kind; cmd_aluop = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 0, 1);
      cmd_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_kind  = 2'($urandom_range(0, 3));
    cmd_aluop = 4'($urandom_range(0, 15));
    cmd_rd    = 5'($urandom_range(0, 31));
    cmd_rs1   = 5'($urandom_range(0, 31));
    cmd_rs2   = 5'($urandom_range(0, 31));
    cmd_imm   = 20'($urandom_range(0, 20'hFFFFF));
    ok = 1'b1;
  endtask

  task automatic send_cmd(input logic [1:0] kind, input logic [3:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [19:0] imm);
    bit          ok;
    logic [31:0] w;
    handshake(kind, op, rd, rs1, rs2, imm, ok);
    if (ok) begin
      if (ref_encode(kind, op, rd, rs1, rs2, imm, w)) expect_write(w);
      else                                            expect_illegal();
    end
  endtask

  task automatic settle_check(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_count"}, 64'(count), 64'(mdl_count));
    check({tag, "_err"},   64'(err),   64'(mdl_err));
    check({tag, "_full"},  64'(full),  64'(mdl_count == DEPTH));
  endtask

  task automatic do_clear();
    check("clear_queue_drained", 64'(exp_q.size()), 0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mdl_count = 0;
    mdl_err   = 1'b0;
    #1;
    check("clear_count", 64'(count), 0);
    check("clear_err",   64'(err),   0);
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [19:0] imm;
    logic [31:0] word;
    bit          legal;
  } vec_t;

  vec_t vecs[11];

  bit          hs_ok;
  bit          held_ok;
  bit          we_seen;
  logic [1:0]  rk;
  logic [3:0]  rop;
  logic [4:0]  rrd, rrs1, rrs2;
  logic [19:0] rimm;

  initial begin
    init_tables();
    vecs[0]  = '{2'd0, 4'b0100, 5'd5,  5'd6,  5'd7,  20'h00000, 32'h407302B3, 1'b1}; // sub
    vecs[1]  = '{2'd1, 4'b0011, 5'd1,  5'd0,  5'd9,  20'h00FFF, 32'hFFF00093, 1'b1}; // addi
    vecs[2]  = '{2'd1, 4'b1010, 5'd2,  5'd2,  5'd0,  20'h00003, 32'h40315113, 1'b1}; // srai
    vecs[3]  = '{2'd2, 4'b1111, 5'd10, 5'd3,  5'd4,  20'h12345, 32'h12345537, 1'b1}; // lui
    vecs[4]  = '{2'd3, 4'b1110, 5'd0,  5'd4,  5'd7,  20'hABF00, 32'hF0021073, 1'b1}; // csrrw
    vecs[5]  = '{2'd0, 4'b1111, 5'd1,  5'd1,  5'd1,  20'h00000, 32'h00000013, 1'b0};
    vecs[6]  = '{2'd0, 4'b0111, 5'd1,  5'd2,  5'd3,  20'h00000, 32'h023130B3, 1'b1}; // mulhu
    vecs[7]  = '{2'd1, 4'b1001, 5'd4,  5'd5,  5'd0,  20'h00ABF, 32'h01F2D213, 1'b1}; // srli
    vecs[8]  = '{2'd1, 4'b0100, 5'd1,  5'd1,  5'd0,  20'h00001, 32'h00000013, 1'b0}; // subi
    vecs[9]  = '{2'd1, 4'b1100, 5'd1,  5'd1,  5'd0,  20'h00001, 32'h00000013, 1'b0}; // slti
    vecs[10] = '{2'd0, 4'b1000, 5'd31, 5'd31, 5'd31, 20'h00000, 32'h01FF9FB3, 1'b1}; // sll

    // reset values while rst_n is held low
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 0);
    check("rst_mem_we",    64'(mem_we),    0);
    check("rst_mem_addr",  64'(mem_addr),  0);
    check("rst_mem_wdata", 64'(mem_wdata), 0);
    check("rst_count",     64'(count),     0);
    check("rst_full",      64'(full),      0);
    check("rst_err",       64'(err),       0);
    rst_n = 1'b1;
    #1 check("ready_after_reset", 64'(cmd_ready), 1);

    // first command: write strobe two edges after the handshake
    send_cmd(2'd0, 4'b0011, 5'd3, 5'd1, 5'd2, 20'h0);
    @(negedge clk);
    check("lat_enc_we", 64'(mem_we), 0);
    check("lat_enc_ready", 64'(cmd_ready), 0);
    @(negedge clk);
    check("lat_write_we",    64'(mem_we),    1);
    check("lat_write_addr",  64'(mem_addr),  0);
    check("lat_write_wdata", 64'(mem_wdata), 64'h002081B3);
    @(negedge clk);
    check("lat_idle_we",    64'(mem_we),    0);
    check("lat_idle_count", 64'(count),     1);
    check("lat_idle_ready", 64'(cmd_ready), 1);

    // table vectors
    for (int i = 0; i < 11; i++) begin
      if (mdl_count == DEPTH) do_clear();
      handshake(vecs[i].kind, vecs[i].aluop, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                hs_ok);
      if (hs_ok) begin
        if (vecs[i].legal) expect_write(vecs[i].word);
        else               expect_illegal();
      end
      settle_check($sformatf("vec%0d", i));
    end

    // fill to capacity with back-to-back commands, then hold a fifth
    settle_check("pre_full");
    do_clear();
    for (int i = 0; i < DEPTH; i++) send_cmd(2'd0, 4'b0011, 5'(i + 1), 5'(i), 5'(i + 2), 20'h0);
    @(negedge clk);
    cmd_kind = 2'd0; cmd_aluop = 4'b0001; cmd_rd = 5'd9; cmd_rs1 = 5'd9; cmd_rs2 = 5'd9;
    cmd_valid = 1'b1;
    held_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cmd_ready) held_ok = 1'b0;
    end
    check("full_held_no_ready", 64'(held_ok), 1);
    check("full_flag",  64'(full),  1);
    check("full_count", 64'(count), DEPTH);
    check("full_queue_drained", 64'(exp_q.size()), 0);
    clear = 1'b1;
    #1 check("clear_cycle_ready", 64'(cmd_ready), 0);
    @(negedge clk);
    clear = 1'b0;
    cmd_valid = 1'b0;
    mdl_count = 0;
    mdl_err = 1'b0;
    #1;
    check("after_clear_count", 64'(count),     0);
    check("after_clear_full",  64'(full),      0);
    check("after_clear_ready", 64'(cmd_ready), 1);

    // clear while the command sits in ENC: nothing may be written
    handshake(2'd0, 4'b0010, 5'd1, 5'd2, 5'd3, 20'h0, hs_ok);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mdl_count = 0;
    mdl_err = 1'b0;
    we_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_we) we_seen = 1'b1;
    end
    check("clear_enc_no_we", 64'(we_seen), 0);
    check("clear_enc_count", 64'(count),   0);

    // clear while in WRITE: strobe suppressed at once
    handshake(2'd2, 4'b0000, 5'd5, 5'd0, 5'd0, 20'h55555, hs_ok);
    @(posedge clk);
    #1 clear = 1'b1;
    #1 check("clear_write_we", 64'(mem_we), 0);
    @(posedge clk);
    #1 clear = 1'b0;
    mdl_count = 0;
    mdl_err = 1'b0;
    settle_check("clear_write");

    // reset during WRITE
    send_cmd(2'd2, 4'b0000, 5'd7, 5'd0, 5'd0, 20'hABCDE);
    settle_check("rst_pre");
    send_cmd(2'd1, 4'b0001, 5'd8, 5'd9, 5'd0, 20'h00F0F);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_we_before", 64'(mem_we), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_we",     64'(mem_we),    0);
    check("rst_mid_count",  64'(count),     0);
    check("rst_mid_addr",   64'(mem_addr),  0);
    check("rst_mid_wdata",  64'(mem_wdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_count = 0;
    mdl_err = 1'b0;
    #1 check("rst_mid_ready", 64'(cmd_ready), 1);

    // random commands against the reference model
    for (int n = 0; n < 150; n++) begin
      if (mdl_count == DEPTH || $urandom_range(0, 9) == 0) begin
        settle_check("rnd_pre_clear");
        do_clear();
      end
      rk   = 2'($urandom_range(0, 3));
      rop  = 4'($urandom_range(0, 15));
      rrd  = 5'($urandom_range(0, 31));
      rrs1 = 5'($urandom_range(0, 31));
      rrs2 = 5'($urandom_range(0, 31));
      rimm = 20'($urandom_range(0, 20'hFFFFF));
      send_cmd(rk, rop, rrd, rrs1, rrs2, rimm);
      if ($urandom_range(0, 1) == 1) settle_check("rnd");
    end

    settle_check("final");
    check("final_queue_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
